lsu_axi_master: RTL and testbench
=================================

# lsu_axi_master

AXI initiator that converts the core's single load/store request into one single-beat AXI read or write transaction on the data-memory port, and returns the load result or store completion to the core. It sits between the LSU stage and the data-side AXI slave (sram or crossbar), driving the same `axi_w_m2s_t`/`axi_r_m2s_t` struct types from `ysyx_24080006_pkg` that the slave consumes. The block handles sub-word alignment: strobe generation, write-data lane shifting, and load-data extraction with sign or zero extension. One transaction is outstanding at a time.

## Interface
- Parameters: none. Address and data are fixed at 32 bits by the package types.
- `clock` in 1 — sole clock; all state updates on posedge.
- `reset` in 1 — asynchronous, active-high.
- `req_valid` in 1 — core request valid.
- `req_ready` out 1 — high only in IDLE with reset deasserted.
- `req_we` in 1 — 1 = store, 0 = load.
- `req_addr` in 32 — byte address.
- `req_wdata` in 32 — store data, right-aligned.
- `req_size` in 2 — 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1 — load zero-extend when 1.
- `rsp_valid` out 1 — response valid; held until `rsp_ready`.
- `rsp_ready` in 1 — core accepts response.
- `rsp_rdata` out 32 — extended load data; 0 for stores and errors.
- `rsp_err` out 1 — misaligned/illegal request, or read beat with `rlast`=0.
- `mem_w_m2s` out `axi_w_m2s_t` — awvalid/awaddr, wvalid/wdata/wstrb, bready.
- `mem_w_s2m` in `axi_w_s2m_t` — awready, wready, bvalid.
- `mem_r_m2s` out `axi_r_m2s_t` — arvalid/araddr, rready.
- `mem_r_s2m` in `axi_r_s2m_t` — arready, rvalid, rdata, rlast.

## Operation
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE: on `req_valid && req_ready`, latch all req fields and compute `off = addr[1:0]`.
  - Misaligned (half with `off[0]`=1; word with `off`≠0) or size=11 → RESP with err=1, rdata=0. No AXI traffic.
  - Otherwise a store goes to WR and a load goes to RD_ADDR.
- Address and strobe generation:
  - awaddr/araddr = `{addr[31:2],2'b00}`.
  - wstrb = (0001 byte | 0011 half | 1111 word) << off.
  - wdata = req_wdata << (8·off).
- WR:
  - awvalid and wvalid are asserted together on entry.
  - Each drops independently after its own handshake (valid&&ready at posedge), tracked by aw_done/w_done flags.
  - When both are done → WR_RESP. Both handshakes may complete in the same cycle.
- WR_RESP: bready=1. On bvalid → RESP, err=0, rdata=0.
- RD_ADDR: arvalid=1. On arready → RD_DATA.
- RD_DATA: rready=1. On rvalid, capture data in this order:
  - shift rdata right by 8·off;
  - byte: take [7:0]; half: take [15:0]; word: take all 32 bits;
  - sign-extend unless `req_unsigned`;
  - err = ~rlast;
  - → RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_err stable. On rsp_ready → IDLE.
- Outputs are all registered or decoded from state. awaddr/wdata/wstrb/araddr stay stable while their valid is high. No valid drops before its handshake.
- Reset, asynchronous:
  - state → IDLE; all done flags cleared;
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err = 0;
  - rsp_rdata = 0; req_ready = 0 while reset is high.
  - Reset mid-transaction abandons it immediately. The slave is reset alongside.

## Timing
- Request accept: cycle 0. AXI valids are visible from cycle 1.
- Store, zero-wait slave: cycle 1 aw/w handshake; cycle 2 bready with bvalid; cycle 3 rsp_valid. Latency is 3 cycles to rsp_valid.
- Load, zero-wait slave: cycle 1 ar handshake; cycle 2 r handshake; cycle 3 rsp_valid.
- Error response: rsp_valid at cycle 1.
- Earliest next req_ready is the cycle after the rsp handshake. Throughput is at most one request per 4 cycles.
- bready and rready are never asserted outside WR_RESP and RD_DATA. A bvalid arriving before both aw/w handshakes complete waits.

## Test plan
- Byte store: `sb` with addr 0x8000_0003, wdata 0x0000_00AB → awaddr 0x8000_0000, wdata 0xAB00_0000, wstrb 1000; rsp_valid at cycle 3 with err=0, rdata=0.
- Signed/unsigned halfword load: addr 0x8000_0002, slave rdata 0x8001_1234 → `lh` returns 0xFFFF_8001 and `lhu` returns 0x0000_8001. Also `lb` at 0x8000_0001 returns 0x0000_0012.
- Misaligned load: `lw` at 0x8000_0001 → arvalid never rises; rsp_valid at cycle 1 with err=1, rdata=0. Size=11 gives the same result.
- Channel skew: wready=1 and awready low for 3 cycles → wvalid drops after cycle 1; awvalid is held with stable awaddr; bready first rises the cycle after the aw handshake. An early bvalid is not consumed.
- Response backpressure: rsp_ready low for 4 cycles → rsp_valid and rsp_rdata are held, req_ready=0, and no AXI valids are asserted. A new request is accepted the cycle after rsp_ready.
- Async reset mid-transaction: reset asserted mid-cycle while arvalid=1 → arvalid, rready and rsp_valid go to 0 without a clock edge. After release the block is in IDLE with req_ready=1, and a fresh load completes correctly.

Source files
------------

// File: rtl/lsu_axi_master.sv
// Shared AXI struct types plus the LSU-side AXI initiator: one single-beat
// read or write per core request, with sub-word strobe/shift/extension.
package ysyx_24080006_pkg;
  typedef struct packed {
    logic        awvalid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;
  } axi_w_m2s_t;

  typedef struct packed {
    logic awready;
    logic wready;
    logic bvalid;
  } axi_w_s2m_t;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;
endpackage

module lsu_axi_master
  import ysyx_24080006_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output axi_w_m2s_t  mem_w_m2s,
  input  axi_w_s2m_t  mem_w_s2m,
  output axi_r_m2s_t  mem_r_m2s,
  input  axi_r_s2m_t  mem_r_s2m
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESP
  } state_t;

  state_t      state, state_nxt;
  logic        aw_done, w_done;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  size_q, off_q;
  logic        unsigned_q, err_q;

  logic        accept, req_bad, aw_hs, w_hs;
  logic [1:0]  req_off;
  logic [3:0]  strb_base;
  logic [31:0] rd_shift, load_ext;

  assign req_ready = (state == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[1:0];
  assign req_bad   = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_off[0])
                   || ((req_size == 2'b10) && (req_off != 2'b00));

  // Each write channel handshakes independently; a channel counts as done
  // either from its flag or from a handshake happening on this very edge.
  assign aw_hs = (state == S_WR) && !aw_done && mem_w_s2m.awready;
  assign w_hs  = (state == S_WR) && !w_done  && mem_w_s2m.wready;

  always_comb begin
    strb_base = 4'b1111;
    case (req_size)
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  always_comb begin
    rd_shift = mem_r_s2m.rdata >> {off_q, 3'b000};
    load_ext = rd_shift;
    case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_ext = {{16{~unsigned_q & rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)     state_nxt = S_RESP;
          else if (req_we) state_nxt = S_WR;
          else             state_nxt = S_RD_ADDR;
        end
      end
      S_WR: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: if (mem_w_s2m.bvalid)  state_nxt = S_RESP;
      S_RD_ADDR: if (mem_r_s2m.arready) state_nxt = S_RD_DATA;
      S_RD_DATA: if (mem_r_s2m.rvalid)  state_nxt = S_RESP;
      S_RESP:    if (rsp_ready)         state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_q     <= '0;
      off_q      <= '0;
      unsigned_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= {req_addr[31:2], 2'b00};
        off_q      <= req_off;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata << {req_off, 3'b000};
        wstrb_q    <= strb_base << req_off;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        if (req_bad) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == S_WR_RESP) && mem_w_s2m.bvalid) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if ((state == S_RD_DATA) && mem_r_s2m.rvalid) begin
        rdata_q <= load_ext;
        err_q   <= ~mem_r_s2m.rlast;
      end
    end
  end

  always_comb begin
    mem_w_m2s         = '0;
    mem_w_m2s.awvalid = (state == S_WR) && !aw_done;
    mem_w_m2s.awaddr  = addr_q;
    mem_w_m2s.wvalid  = (state == S_WR) && !w_done;
    mem_w_m2s.wdata   = wdata_q;
    mem_w_m2s.wstrb   = wstrb_q;
    mem_w_m2s.bready  = (state == S_WR_RESP);
  end

  always_comb begin
    mem_r_m2s         = '0;
    mem_r_m2s.arvalid = (state == S_RD_ADDR);
    mem_r_m2s.araddr  = addr_q;
    mem_r_m2s.rready  = (state == S_RD_DATA);
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: a reactive slave, an arithmetic model of
// the expected AXI fields and response, and literal pins for key cases.
module tb_lsu_axi_master;
  import ysyx_24080006_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  axi_w_m2s_t  mem_w_m2s;
  axi_w_s2m_t  mem_w_s2m = '0;
  axi_r_m2s_t  mem_r_m2s;
  axi_r_s2m_t  mem_r_s2m = '0;

  lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_w_m2s(mem_w_m2s), .mem_w_s2m(mem_w_s2m),
    .mem_r_m2s(mem_r_m2s), .mem_r_s2m(mem_r_s2m)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave configuration and state
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  logic        early_b = 1'b0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_rlast = 1'b1;
  logic        got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic        p_aw = 1'b0, p_w = 1'b0, p_b = 1'b0, p_ar = 1'b0, p_r = 1'b0;

  // Slave: acts on negedges; valids seen at the previous negedge were the
  // ones presented at the posedge in between.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      mem_w_s2m = '0; mem_r_s2m = '0;
      got_aw = 0; got_w = 0; got_ar = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    end else begin
      if (p_aw && mem_w_s2m.awready) got_aw = 1;
      if (p_w && mem_w_s2m.wready)   got_w = 1;
      if (p_b && mem_w_s2m.bvalid) begin got_aw = 0; got_w = 0; end
      if (p_ar && mem_r_s2m.arready) got_ar = 1;
      if (p_r && mem_r_s2m.rvalid)   got_ar = 0;

      if (mem_w_m2s.awvalid) begin mem_w_s2m.awready = (aw_cnt >= aw_delay); aw_cnt++; end
      else begin mem_w_s2m.awready = 0; aw_cnt = 0; end
      if (mem_w_m2s.wvalid) begin mem_w_s2m.wready = (w_cnt >= w_delay); w_cnt++; end
      else begin mem_w_s2m.wready = 0; w_cnt = 0; end
      if (mem_r_m2s.arvalid) begin mem_r_s2m.arready = (ar_cnt >= ar_delay); ar_cnt++; end
      else begin mem_r_s2m.arready = 0; ar_cnt = 0; end

      mem_w_s2m.bvalid = (got_aw && got_w)
                       || (early_b && (mem_w_m2s.awvalid || mem_w_m2s.wvalid));
      mem_r_s2m.rvalid = got_ar;
      mem_r_s2m.rdata  = cfg_rdata;
      mem_r_s2m.rlast  = cfg_rlast;

      p_aw = mem_w_m2s.awvalid; p_w = mem_w_m2s.wvalid; p_b = mem_w_m2s.bready;
      p_ar = mem_r_m2s.arvalid; p_r = mem_r_m2s.rready;
    end
  end

  // Expected transaction
  logic        exp_active = 1'b0, exp_we = 1'b0, exp_ill = 1'b0, exp_err = 1'b0, exp_chk_rd = 1'b1;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  logic [3:0]  exp_strb = '0;
  logic [31:0] last_awaddr = '0, last_wdata = '0, last_rdata = '0;
  logic [3:0]  last_wstrb = '0;
  logic        last_err = 1'b0;

  function automatic void model(
    input  logic we, input logic [31:0] addr, input logic [31:0] wd,
    input  logic [1:0] size, input logic uns,
    input  logic [31:0] mrd, input logic mlast,
    output logic ill, output logic [31:0] aaddr, output logic [31:0] awd,
    output logic [3:0] strb, output logic [31:0] rd, output logic err);
    int nb, off;
    longint v, full;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = int'(addr % 32'd4);
    ill   = (size == 2'd3) || ((off % nb) != 0);
    aaddr = addr - 32'(off);
    strb  = 4'(((1 << nb) - 1) << off);
    awd   = 32'(longint'(wd) * (longint'(1) << (8 * off)));
    full  = longint'(1) << (8 * nb);
    v     = longint'(mrd >> (8 * off)) % full;
    if (!uns && v >= full / 2) v = v - full;
    rd    = (ill || we) ? 32'd0 : 32'(v);
    err   = ill ? 1'b1 : (we ? 1'b0 : !mlast);
  endfunction

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clock);
    #1;
    if (!reset) begin
      if (mem_w_m2s.awvalid) begin
        last_awaddr = mem_w_m2s.awaddr;
        check("awvalid_after_hs", 32'(got_aw), 32'd0);
      end
      if (mem_w_m2s.wvalid) begin
        last_wdata = mem_w_m2s.wdata;
        last_wstrb = mem_w_m2s.wstrb;
        check("wvalid_after_hs", 32'(got_w), 32'd0);
      end
      if (mem_w_m2s.bready) check("bready_before_aw_w", 32'(got_aw && got_w), 32'd1);
      if (exp_active) begin
        if (mem_w_m2s.awvalid) check("awaddr", mem_w_m2s.awaddr, exp_addr);
        if (mem_w_m2s.wvalid) begin
          check("wdata", mem_w_m2s.wdata, exp_wdata);
          check("wstrb", 32'(mem_w_m2s.wstrb), 32'(exp_strb));
        end
        if (mem_r_m2s.arvalid) check("araddr", mem_r_m2s.araddr, exp_addr);
        if (exp_ill)
          check("no_axi_on_err", 32'(mem_w_m2s.awvalid | mem_w_m2s.wvalid | mem_r_m2s.arvalid), 32'd0);
        if (rsp_valid) begin
          check("rsp_err", 32'(rsp_err), 32'(exp_err));
          if (exp_chk_rd) check("rsp_rdata", rsp_rdata, exp_rdata);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns);
    int w = 0;
    while (!req_ready && w < 50) begin @(posedge clock); #1; w++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    model(we, addr, wd, size, uns, cfg_rdata, cfg_rlast,
          exp_ill, exp_addr, exp_wdata, exp_strb, exp_rdata, exp_err);
    exp_we     = we;
    exp_chk_rd = we || exp_ill || cfg_rlast;
    exp_active = 1;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
    @(posedge clock); #1;
    req_valid = 0;
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] size, input logic uns, input int exp_lat, input int hold);
    int lat;
    logic [31:0] held;
    issue(we, addr, wd, size, uns);
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge clock); #1; lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    held       = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, held);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_no_axi", 32'(mem_w_m2s.awvalid | mem_w_m2s.wvalid | mem_r_m2s.arvalid), 32'd0);
    end
    rsp_ready = 1;
    @(posedge clock); #1;
    rsp_ready  = 0;
    exp_active = 0;
    check("ready_after_rsp", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_valids", 32'(mem_w_m2s.awvalid | mem_w_m2s.wvalid | mem_w_m2s.bready
                           | mem_r_m2s.arvalid | mem_r_m2s.rready), 32'd0);
    repeat (3) @(negedge clock);
    reset = 0;
    @(posedge clock); #1;

    // sb at byte 3
    run(1, 32'h8000_0003, 32'h0000_00AB, 2'b00, 0, 3, 0);
    check("sb_awaddr", last_awaddr, 32'h8000_0000);
    check("sb_wdata", last_wdata, 32'hAB00_0000);
    check("sb_wstrb", 32'(last_wstrb), 32'h8);
    check("sb_rdata", last_rdata, 32'h0);
    check("sb_err", 32'(last_err), 32'd0);

    run(1, 32'h8000_0010, 32'h1122_3344, 2'b10, 0, 3, 0);
    run(1, 32'h8000_0002, 32'h0000_BEEF, 2'b01, 0, 3, 0);
    check("sh_wstrb", 32'(last_wstrb), 32'hC);

    cfg_rdata = 32'h8001_1234;
    run(0, 32'h8000_0002, 32'h0, 2'b01, 0, 3, 0);
    check("lh_rdata", last_rdata, 32'hFFFF_8001);
    run(0, 32'h8000_0002, 32'h0, 2'b01, 1, 3, 0);
    check("lhu_rdata", last_rdata, 32'h0000_8001);
    run(0, 32'h8000_0001, 32'h0, 2'b00, 0, 3, 0);
    check("lb_rdata", last_rdata, 32'h0000_0012);
    run(0, 32'h8000_0003, 32'h0, 2'b00, 0, 3, 0);
    check("lb_sign", last_rdata, 32'hFFFF_FF80);
    run(0, 32'h8000_0000, 32'h0, 2'b10, 0, 3, 0);

    // Illegal / misaligned
    run(0, 32'h8000_0001, 32'h0, 2'b10, 0, 1, 0);
    check("lw_mis_err", 32'(last_err), 32'd1);
    check("lw_mis_rdata", last_rdata, 32'h0);
    run(0, 32'h8000_0000, 32'h0, 2'b11, 0, 1, 0);
    check("size11_err", 32'(last_err), 32'd1);
    run(1, 32'h8000_0001, 32'h1234, 2'b01, 0, 1, 0);

    // Channel skew with an early bvalid
    aw_delay = 3; early_b = 1;
    run(1, 32'h8000_0020, 32'hCAFE_F00D, 2'b10, 0, 6, 0);
    check("skew_awaddr", last_awaddr, 32'h8000_0020);
    aw_delay = 0; early_b = 0;
    w_delay = 2;
    run(1, 32'h8000_0025, 32'h0000_005A, 2'b00, 0, 5, 0);
    w_delay = 0;

    // Response backpressure, then back-to-back request
    cfg_rdata = 32'h1357_2468;
    run(0, 32'h8000_0004, 32'h0, 2'b10, 0, 3, 4);
    check("bp_rdata", last_rdata, 32'h1357_2468);
    run(0, 32'h8000_0006, 32'h0, 2'b01, 1, 3, 0);
    check("bp_next_lhu", last_rdata, 32'h0000_1357);

    // Read beat without rlast
    cfg_rlast = 0;
    run(0, 32'h8000_0008, 32'h0, 2'b10, 0, 3, 0);
    check("rlast_err", 32'(last_err), 32'd1);
    cfg_rlast = 1;

    // Async reset while arvalid is high
    ar_delay = 10;
    issue(0, 32'h8000_0004, 32'h0, 2'b10, 0);
    @(negedge clock);
    check("arvalid_pre_rst", 32'(mem_r_m2s.arvalid), 32'd1);
    #2 reset = 1;
    #1;
    check("rst_arvalid", 32'(mem_r_m2s.arvalid), 32'd0);
    check("rst_rready", 32'(mem_r_m2s.rready), 32'd0);
    check("rst_rsp_valid2", 32'(rsp_valid), 32'd0);
    check("rst_req_ready2", 32'(req_ready), 32'd0);
    exp_active = 0;
    ar_delay = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    @(posedge clock); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    cfg_rdata = 32'hDEAD_BEEF;
    run(0, 32'h8000_000C, 32'h0, 2'b10, 0, 3, 0);
    check("post_rst_lw", last_rdata, 32'hDEAD_BEEF);

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
